// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache, one word per line.
// Ports: clk/rstN; processor req/mode/addr/inData -> ready/done/hit/outData;
// memory memReq/memWe/memAddr/memWData -> memRData/memAck. True LRU via ages.
module set_assoc_cache #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              req,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] inData,
    output logic              ready,
    output logic              done,
    output logic              hit,
    output logic [DATA_W-1:0] outData,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck
);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_W - IW;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;

    state_t            state_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];
    logic [WW-1:0]     age_q   [SETS][WAYS];

    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WW-1:0]     victim_q;

    logic              ready_q, done_q, hit_q, memReq_q, memWe_q;
    logic [DATA_W-1:0] outData_q, memWData_q;
    logic [ADDR_W-1:0] memAddr_q;

    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              hit_any, inv_found, lru_upd;
    logic [WW-1:0]     hit_way, inv_way, lru_way, victim, acc_way;

    assign idx = addr_q[IW-1:0];
    assign tag = addr_q[ADDR_W-1:IW];

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
            if (age_q[idx][w] == WW'(WAYS - 1)) begin
                lru_way = WW'(w);
            end
        end
        victim  = inv_found ? inv_way : lru_way;
        // Ages move on a hit in LOOKUP or on a line install in FILL.
        lru_upd = (state_q == LOOKUP && hit_any) ||
                  (state_q == FILL && memReq_q && memAck);
        acc_way = (state_q == LOOKUP) ? hit_way : victim_q;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            outData_q  <= '0;
            memAddr_q  <= '0;
            memWData_q <= '0;
            mode_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            victim_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WW'(w);
                end
            end
        end else begin
            done_q <= 1'b0;
            if (lru_upd && WAYS > 1) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (WW'(v) == acc_way) begin
                        age_q[idx][v] <= '0;
                    end else if (age_q[idx][v] < age_q[idx][acc_way]) begin
                        age_q[idx][v] <= age_q[idx][v] + WW'(1);
                    end
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        mode_q  <= mode;
                        addr_q  <= addr;
                        wdata_q <= inData;
                        ready_q <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_any) begin
                        if (mode_q) begin
                            data_q[idx][hit_way]  <= wdata_q;
                            dirty_q[idx][hit_way] <= 1'b1;
                        end else begin
                            outData_q <= data_q[idx][hit_way];
                        end
                        hit_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        victim_q <= victim;
                        hit_q    <= 1'b0;
                        memReq_q <= 1'b1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            memWe_q    <= 1'b1;
                            memAddr_q  <= {tag_q[idx][victim], idx};
                            memWData_q <= data_q[idx][victim];
                            state_q    <= WB;
                        end else begin
                            memWe_q   <= 1'b0;
                            memAddr_q <= addr_q;
                            state_q   <= FILL;
                        end
                    end
                end
                WB: begin
                    if (memAck) begin
                        // Drop memReq for a cycle before the fill starts.
                        memReq_q  <= 1'b0;
                        memWe_q   <= 1'b0;
                        memAddr_q <= addr_q;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (!memReq_q) begin
                        memReq_q <= 1'b1;
                    end else if (memAck) begin
                        memReq_q              <= 1'b0;
                        valid_q[idx][victim_q] <= 1'b1;
                        tag_q[idx][victim_q]   <= tag;
                        if (mode_q) begin
                            data_q[idx][victim_q]  <= wdata_q;
                            dirty_q[idx][victim_q] <= 1'b1;
                        end else begin
                            data_q[idx][victim_q]  <= memRData;
                            dirty_q[idx][victim_q] <= 1'b0;
                            outData_q              <= memRData;
                        end
                        hit_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign hit      = hit_q;
    assign outData  = outData_q;
    assign memReq   = memReq_q;
    assign memWe    = memWe_q;
    assign memAddr  = memAddr_q;
    assign memWData = memWData_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Testbench for set_assoc_cache: scenario tasks plus randomized traffic
// checked against a recency-list cache model and a word-addressed memory.
module tb_set_assoc_cache;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;
    localparam int IW     = 4;

    logic              clk = 1'b0;
    logic              rstN, req, mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inData;
    logic              ready, done, hit;
    logic [DATA_W-1:0] outData;
    logic              memReq, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              memAck;

    always #5 clk = ~clk;

    set_assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk(clk), .rstN(rstN), .req(req), .mode(mode), .addr(addr),
        .inData(inData), .ready(ready), .done(done), .hit(hit),
        .outData(outData), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWData(memWData), .memRData(memRData),
        .memAck(memAck)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } mtx_t;

    typedef struct {
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
        bit                dirty;
    } line_t;

    mtx_t              memLog[$];
    logic [DATA_W-1:0] dutMem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
    line_t             cset [SETS][$];
    logic [DATA_W-1:0] lastRead = '0;

    function automatic logic [DATA_W-1:0] rd_dut(logic [ADDR_W-1:0] a);
        return dutMem.exists(a) ? dutMem[a] : DATA_W'(a) + 1;
    endfunction

    function automatic logic [DATA_W-1:0] rd_ref(logic [ADDR_W-1:0] a);
        return refMem.exists(a) ? refMem[a] : DATA_W'(a) + 1;
    endfunction

    // Memory: acks on the third edge after memReq is seen high.
    int rcnt;
    initial begin
        logic [DATA_W-1:0] d;
        memAck = 1'b0; memRData = '0; rcnt = 0;
        forever begin
            @(posedge clk); #2;
            memAck = 1'b0;
            if (rstN !== 1'b1 || memReq !== 1'b1) begin
                rcnt = 0;
            end else begin
                rcnt++;
                if (rcnt == 3) begin
                    rcnt = 0;
                    memAck = 1'b1;
                    if (memWe) begin
                        d = memWData;
                        dutMem[memAddr] = memWData;
                    end else begin
                        d = rd_dut(memAddr);
                        memRData = d;
                    end
                    memLog.push_back('{memWe, memAddr, d});
                end
            end
        end
    end

    // Reference model: per-set list ordered most-recent first.
    function automatic void ref_access(input bit m, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d,
                                       output bit eh, output logic [DATA_W-1:0] ed,
                                       output mtx_t ex[$]);
        int ix;
        int hi;
        logic [ADDR_W-1:0] tg;
        line_t ln, v;
        ex.delete();
        ix = int'(a % ADDR_W'(SETS));
        tg = a >> IW;
        hi = -1;
        for (int i = 0; i < cset[ix].size(); i++)
            if (cset[ix][i].tag == tg) hi = i;
        if (hi >= 0) begin
            eh = 1'b1;
            ln = cset[ix][hi];
            cset[ix].delete(hi);
        end else begin
            eh = 1'b0;
            if (cset[ix].size() == WAYS) begin
                v = cset[ix].pop_back();
                if (v.dirty) begin
                    ex.push_back('{1'b1, ADDR_W'(v.tag * SETS + ix), v.data});
                    refMem[ADDR_W'(v.tag * SETS + ix)] = v.data;
                end
            end
            ex.push_back('{1'b0, a, rd_ref(a)});
            ln.tag = tg; ln.data = rd_ref(a); ln.dirty = 1'b0;
        end
        if (m) begin
            ln.data = d; ln.dirty = 1'b1;
        end else begin
            lastRead = ln.data;
        end
        ed = lastRead;
        cset[ix].push_front(ln);
    endfunction

    function automatic void ref_reset();
        for (int s = 0; s < SETS; s++) cset[s].delete();
        lastRead = '0;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        n_chk++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: ready=%b required 1", ready);
        end
    endtask

    // One processor transaction, checked against the model.
    task automatic do_req(input bit m, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit inject,
                          output bit oh, output logic [DATA_W-1:0] od, output int lat);
        bit eh, sawReq, txok;
        logic [DATA_W-1:0] ed;
        mtx_t ex[$];
        ref_access(m, a, d, eh, ed, ex);
        wait_ready();
        memLog.delete();
        req = 1'b1; mode = m; addr = a; inData = d;
        @(posedge clk); #1;
        req = 1'b0; lat = 1; sawReq = 1'b0;
        if (inject) begin
            req = 1'b1; mode = ~m; addr = a ^ 24'h5A5A50; inData = ~d;
        end
        while (done !== 1'b1 && lat < 100) begin
            sawReq |= (memReq === 1'b1);
            @(posedge clk); #1; lat++;
            if (lat >= 3) req = 1'b0;
        end
        req = 1'b0;
        oh = hit; od = outData;
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: addr=%h done=%b after %0d cycles", a, done, lat);
        end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b ready=%b required 0/1", done, ready);
        end
        n_chk++;
        if (oh !== eh) begin
            n_fail++;
            $display("FAIL hit: addr=%h got %b required %b", a, oh, eh);
        end
        n_chk++;
        if (od !== ed) begin
            n_fail++;
            $display("FAIL outData: addr=%h got %h required %h", a, od, ed);
        end
        txok = (memLog.size() == ex.size()) && (sawReq == (ex.size() != 0));
        if (txok)
            for (int i = 0; i < ex.size(); i++)
                if (memLog[i].we !== ex[i].we || memLog[i].a !== ex[i].a ||
                    memLog[i].d !== ex[i].d) txok = 1'b0;
        n_chk++;
        if (!txok) begin
            n_fail++;
            $display("FAIL memtx: addr=%h got %0d txns (req seen %b) required %0d",
                     a, memLog.size(), sawReq, ex.size());
        end
    endtask

    task automatic test_reset();
        req = 1'b0; mode = 1'b0; addr = '0; inData = '0;
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        ref_reset();
        n_chk++;
        if (ready !== 1'b1 || done !== 1'b0 || hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/done/hit=%b%b%b required 100", ready, done, hit);
        end
        n_chk++;
        if (memReq !== 1'b0 || memWe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem: memReq/memWe=%b%b required 00", memReq, memWe);
        end
        n_chk++;
        if (outData !== '0 || memAddr !== '0 || memWData !== '0) begin
            n_fail++;
            $display("FAIL reset_data: %h %h %h required 0", outData, memAddr, memWData);
        end
    endtask

    task automatic test_read_fill();
        bit h; logic [DATA_W-1:0] d; int lat;
        do_req(1'b0, 24'h000010, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b0 || d !== 32'h11 || memLog.size() != 1 || memLog[0].a !== 24'h10) begin
            n_fail++;
            $display("FAIL read_miss: hit=%b data=%h required 0/00000011", h, d);
        end
        do_req(1'b0, 24'h000010, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b1 || d !== 32'h11 || lat != 2) begin
            n_fail++;
            $display("FAIL read_hit: hit=%b data=%h lat=%0d required 1/11/2", h, d, lat);
        end
    endtask

    task automatic test_write_hit();
        bit h; logic [DATA_W-1:0] d; int lat;
        do_req(1'b1, 24'h000010, 32'd46426, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b1 || memLog.size() != 0) begin
            n_fail++;
            $display("FAIL write_hit: hit=%b txns=%0d required 1/0", h, memLog.size());
        end
        do_req(1'b0, 24'h000010, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b1 || d !== 32'd46426 || memLog.size() != 0) begin
            n_fail++;
            $display("FAIL write_readback: hit=%b data=%0d required 1/46426", h, d);
        end
    endtask

    task automatic test_conflict();
        bit h; logic [DATA_W-1:0] d; int lat;
        do_req(1'b0, 24'h000020, '0, 1'b0, h, d, lat);
        do_req(1'b0, 24'h000030, '0, 1'b0, h, d, lat);
        n_chk++;
        if (memLog.size() != 2 || memLog[0].we !== 1'b1 || memLog[0].a !== 24'h10 ||
            memLog[0].d !== 32'd46426 || memLog[1].a !== 24'h30 || d !== 32'h31) begin
            n_fail++;
            $display("FAIL conflict_wb: txns=%0d data=%h required 2/00000031",
                     memLog.size(), d);
        end
        do_req(1'b0, 24'h000020, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_hit: hit=%b required 1", h);
        end
    endtask

    task automatic test_write_miss();
        bit h; logic [DATA_W-1:0] d; int lat;
        do_req(1'b1, 24'hA7E5FB, 32'd4235, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b0) begin
            n_fail++;
            $display("FAIL write_miss: hit=%b required 0", h);
        end
        do_req(1'b0, 24'hA7E5FB, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b1 || d !== 32'd4235) begin
            n_fail++;
            $display("FAIL write_miss_rb: hit=%b data=%0d required 1/4235", h, d);
        end
        do_req(1'b0, 24'h00000B, '0, 1'b0, h, d, lat);
        do_req(1'b0, 24'h00001B, '0, 1'b0, h, d, lat);
        n_chk++;
        if (memLog.size() < 1 || memLog[0].we !== 1'b1 || memLog[0].a !== 24'hA7E5FB ||
            memLog[0].d !== 32'd4235) begin
            n_fail++;
            $display("FAIL write_miss_evict: txns=%0d required writeback of 4235",
                     memLog.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        bit h; logic [DATA_W-1:0] d; int lat; int w;
        do_req(1'b0, 24'h000010, '0, 1'b0, h, d, lat);
        wait_ready();
        req = 1'b1; mode = 1'b0; addr = 24'h000040;
        @(posedge clk); #1;
        req = 1'b0; w = 0;
        while (!(memReq === 1'b1 && memWe === 1'b0) && w < 20) begin
            @(posedge clk); #1; w++;
        end
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        ref_reset();
        n_chk++;
        if (memReq !== 1'b0 || ready !== 1'b1 || w >= 20) begin
            n_fail++;
            $display("FAIL reset_fill: memReq=%b ready=%b required 0/1", memReq, ready);
        end
        memLog.delete();
        do_req(1'b0, 24'h000010, '0, 1'b0, h, d, lat);
        n_chk++;
        if (h !== 1'b0 || d !== 32'd46426) begin
            n_fail++;
            $display("FAIL reset_reread: hit=%b data=%0d required 0/46426", h, d);
        end
    endtask

    task automatic test_req_while_busy();
        bit h; logic [DATA_W-1:0] d; int lat; int extra;
        for (int k = 0; k < 2; k++) begin
            do_req(1'b0, 24'h000050, '0, 1'b1, h, d, lat);
            extra = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (done === 1'b1) extra++;
            end
            n_chk++;
            if (extra != 0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ignore: extra dones=%0d ready=%b required 0/1", extra, ready);
            end
        end
    endtask

    task automatic test_random();
        bit h; logic [DATA_W-1:0] d; int lat;
        logic [ADDR_W-1:0] a;
        int ts;
        for (int n = 0; n < 400; n++) begin
            ts = $urandom_range(0, 5);
            a = (ts >= 4) ? ADDR_W'(24'hFFFFF0 - ts * SETS) : ADDR_W'(ts * SETS);
            a[IW-1:0] = IW'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, DATA_W'($urandom),
                   ($urandom_range(0, 7) == 0), h, d, lat);
            n_chk++;
            if (h === 1'b1 && lat != 2) begin
                n_fail++;
                $display("FAIL rand_hit_latency: lat=%0d required 2", lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_write_hit();
        test_conflict();
        test_write_miss();
        test_reset_mid_fill();
        test_req_while_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
